// File: rtl/qfmt_bcd_if.sv
// Quotient-to-BCD conversion bus: divider-side inputs plus decimal result outputs.
interface qfmt_bcd_if;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_warn;
  logic [19:0] int_bcd;
  logic [15:0] frac_bcd;
  logic        neg;
  logic        err;
  logic        out_valid;
  logic        busy;

  // Upstream / consumer side: drives the divider result, observes the decimal result.
  modport master (
    output in_data, in_valid, in_warn,
    input  int_bcd, frac_bcd, neg, err, out_valid, busy
  );

  // Converter side.
  modport slave (
    input  in_data, in_valid, in_warn,
    output int_bcd, frac_bcd, neg, err, out_valid, busy
  );
endinterface

// File: rtl/qfmt_bcd.sv
// Sign-magnitude Q15.16 to BCD converter.
// Integer part: 15-step double-dabble into 5 digits. Fraction: 4 truncating x10 steps.
// Results are staged internally and published together on a one-cycle out_valid pulse.
module qfmt_bcd (
  input logic        clk,
  input logic        rst_n,
  qfmt_bcd_if.slave  bus
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_CONV_INT  = 2'd1;
  localparam logic [1:0] ST_CONV_FRAC = 2'd2;
  localparam logic [1:0] ST_DONE      = 2'd3;

  localparam logic [3:0] INT_LAST  = 4'd14;
  localparam logic [3:0] FRAC_LAST = 4'd3;

  logic [1:0]  state_r;
  logic [3:0]  cnt_r;
  logic        valid_prev_r;
  logic        warn_prev_r;
  logic [14:0] int_sr_r;
  logic [15:0] frac_r;
  logic [19:0] int_acc_r;
  logic [15:0] frac_acc_r;
  logic        sign_r;
  logic [19:0] int_bcd_r;
  logic [15:0] frac_bcd_r;
  logic        neg_r;
  logic        err_r;
  logic        out_valid_r;
  logic        busy_r;

  logic        valid_rise_s;
  logic        warn_rise_s;
  logic [19:0] dabble_s;
  logic [19:0] frac_prod_s;

  // One double-dabble step: add 3 to every digit >= 5, then shift in the next bit.
  function automatic logic [19:0] dabble_step(input logic [19:0] bcd, input logic shift_bit);
    logic [19:0] adj;
    adj = bcd;
    for (int k = 0; k < 5; k++) begin
      if (bcd[4*k +: 4] >= 4'd5) begin
        adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
      end else begin
        adj[4*k +: 4] = bcd[4*k +: 4];
      end
    end
    return {adj[18:0], shift_bit};
  endfunction

  // Edge detection and per-step datapath values.
  always_comb begin
    valid_rise_s = bus.in_valid & ~valid_prev_r;
    warn_rise_s  = bus.in_warn & ~warn_prev_r;
    dabble_s     = dabble_step(int_acc_r, int_sr_r[14]);
    frac_prod_s  = {4'd0, frac_r} * 20'd10;
  end

  // Previous-value flags for the two level inputs; cleared by reset so a high level
  // at release counts as a fresh rising edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_prev_r <= 1'b0;
      warn_prev_r  <= 1'b0;
    end else begin
      valid_prev_r <= bus.in_valid;
      warn_prev_r  <= bus.in_warn;
    end
  end

  // Conversion FSM, staging registers and published outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 4'd0;
      int_sr_r    <= 15'd0;
      frac_r      <= 16'd0;
      int_acc_r   <= 20'd0;
      frac_acc_r  <= 16'd0;
      sign_r      <= 1'b0;
      int_bcd_r   <= 20'd0;
      frac_bcd_r  <= 16'd0;
      neg_r       <= 1'b0;
      err_r       <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      out_valid_r <= 1'b0;
      if (warn_rise_s) begin
        // Divide-by-zero pre-empts everything, including a simultaneous valid edge.
        state_r     <= ST_IDLE;
        cnt_r       <= 4'd0;
        int_bcd_r   <= 20'd0;
        frac_bcd_r  <= 16'd0;
        neg_r       <= 1'b0;
        err_r       <= 1'b1;
        out_valid_r <= 1'b1;
        busy_r      <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (valid_rise_s) begin
              int_sr_r   <= bus.in_data[30:16];
              frac_r     <= bus.in_data[15:0];
              // Negative zero is reported as positive.
              sign_r     <= bus.in_data[31] & (|bus.in_data[30:0]);
              int_acc_r  <= 20'd0;
              frac_acc_r <= 16'd0;
              cnt_r      <= 4'd0;
              busy_r     <= 1'b1;
              state_r    <= ST_CONV_INT;
            end else begin
              state_r    <= ST_IDLE;
            end
          end
          ST_CONV_INT: begin
            int_acc_r <= dabble_s;
            int_sr_r  <= {int_sr_r[13:0], 1'b0};
            if (cnt_r == INT_LAST) begin
              cnt_r   <= 4'd0;
              state_r <= ST_CONV_FRAC;
            end else begin
              cnt_r   <= cnt_r + 4'd1;
            end
          end
          ST_CONV_FRAC: begin
            // Integer part of frac*10 is the next decimal digit; the rest carries on.
            frac_r     <= frac_prod_s[15:0];
            frac_acc_r <= {frac_acc_r[11:0], frac_prod_s[19:16]};
            if (cnt_r == FRAC_LAST) begin
              cnt_r   <= 4'd0;
              state_r <= ST_DONE;
            end else begin
              cnt_r   <= cnt_r + 4'd1;
            end
          end
          ST_DONE: begin
            int_bcd_r   <= int_acc_r;
            frac_bcd_r  <= frac_acc_r;
            neg_r       <= sign_r;
            err_r       <= 1'b0;
            out_valid_r <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= ST_IDLE;
          end
          default: begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.int_bcd   = int_bcd_r;
  assign bus.frac_bcd  = frac_bcd_r;
  assign bus.neg       = neg_r;
  assign bus.err       = err_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = busy_r;

endmodule

// File: doc/qfmt_bcd.md
QFMT_BCD -- requirements
Module: qfmt_bcd

Interface
REQ-001 Parameters: none; input format fixed at sign-magnitude Q15.16 (bit 31 sign, [30:16] integer, [15:0] fraction).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset: one clock; reset is synchronous and active-low.
REQ-004 in_data  input  32  quotient word from upstream fixed-point divider.
REQ-005 in_valid  input  1  divider result-ready level; conversion triggers on 0->1 transition only.
REQ-006 in_warn  input  1  divider divide-by-zero level; error path triggers on 0->1 transition only.
REQ-007 int_bcd  output  20  integer part, 5 BCD digits, [19:16] most significant.
REQ-008 frac_bcd  output  16  fraction, 4 BCD digits, [15:12] = tenths.
REQ-009 neg  output  1  result sign.
REQ-010 err  output  1  last event was divide-by-zero.
REQ-011 out_valid  output  1  one-cycle pulse: new int_bcd/frac_bcd/neg/err available.
REQ-012 busy  output  1  conversion in progress.

Function
REQ-013 Block SHALL register in_valid and in_warn each cycle as previous-value flags; rising edge = current 1 and previous 0.
REQ-014 FSM states SHALL be IDLE, CONV_INT, CONV_FRAC, DONE.
REQ-015 IDLE + in_valid rising edge at edge T (no in_warn rising edge): capture magnitude, sign, clear err; busy=1 from T; go CONV_INT.
REQ-016 CONV_INT SHALL run 15 double-dabble iterations (add-3 to any digit >=5, then shift in next integer bit, MSB first) at edges T+1..T+15.
REQ-017 CONV_FRAC SHALL run 4 iterations at edges T+16..T+19: frac*10 (20-bit product), digit = product[19:16], frac = product[15:0].
REQ-018 Fraction digits SHALL be truncated, never rounded.
REQ-019 At edge T+20 (DONE): outputs updated, out_valid=1 for exactly one cycle, busy=0, return IDLE; latency 20 cycles capture-to-out_valid.
REQ-020 int_bcd/frac_bcd/neg/err SHALL hold between out_valid pulses; no intermediate values visible on outputs.
REQ-021 neg SHALL be 0 when integer and fraction magnitudes are both zero (negative zero normalised).
REQ-022 in_warn rising edge in any state at edge T: abort any conversion, int_bcd=0, frac_bcd=0, neg=0, err=1, out_valid=1 at T+1, busy=0, state IDLE.
REQ-023 Simultaneous in_valid and in_warn rising edges: warn path wins, no conversion starts.
REQ-024 in_valid rising edge while busy SHALL be ignored (no restart, no queue); edge flag still updated.
REQ-025 in_valid held high SHALL NOT retrigger; must return low before next conversion.

Reset
REQ-026 rst_n=0 at a rising edge SHALL set int_bcd=0, frac_bcd=0, neg=0, err=0, out_valid=0, busy=0, both edge flags=0, state IDLE, aborting any conversion.
REQ-027 in_valid or in_warn already high when rst_n releases SHALL be treated as a rising edge at the first post-reset edge.
REQ-028 rst_n asserted asynchronously to clk SHALL have no effect until the next rising edge.

Verification
REQ-029 in_data=0x00018000, in_valid 0->1 -> 20 cycles later out_valid pulse, int_bcd=0x00001, frac_bcd=0x5000, neg=0, err=0.
REQ-030 in_data=0x8003243F -> int_bcd=0x00003, frac_bcd=0x1415, neg=1; in_data=0x7FFFFFFF -> int_bcd=0x32767, frac_bcd=0x9999, neg=0.
REQ-031 in_data=0x80000000 -> int_bcd=0x00000, frac_bcd=0x0000, neg=0.
REQ-032 in_warn 0->1 at cycle 10 of a running conversion -> out_valid at next cycle, err=1, all digits 0, busy=0; no later pulse from aborted conversion.
REQ-033 in_valid held high for 50 cycles -> exactly one out_valid pulse; second 0->1 during busy -> ignored, still one pulse.
REQ-034 rst_n low for one edge mid-conversion -> all outputs 0 next cycle, no out_valid pulse; in_valid high at release -> full conversion completes 20 cycles later.
